// File: rtl/cnt163_pkg.sv
// Shared types and constants for the cnt163 sequencing controller and its 4-bit slices.
package cnt163_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_START = 2'b10,
    OP_STOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_EXPIRE = 2'b10
  } state_e;

endpackage

// File: rtl/cnt163_slice.sv
// One 4-bit synchronous load/count slice (163-style) with ripple carry-out.
module cnt163_slice
  import cnt163_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld,
  input  logic [SLICE_W-1:0] d,
  input  logic               cen,
  output logic [SLICE_W-1:0] q,
  output logic               co
);

  logic [SLICE_W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (ld) begin
      q_q <= d;
    end else if (cen) begin
      q_q <= q_q + SLICE_W'(1);
    end
  end

  assign q  = q_q;
  assign co = cen & (q_q == '1);

endmodule

// File: rtl/cnt163_seq_ctrl.sv
// Command sequencer driving a cascade of cnt163_slice counters as one wide timer.
// Optional tick prescaler enabled by defining CNT163_PRESCALE_EN.
module cnt163_seq_ctrl
  import cnt163_pkg::*;
#(
  parameter int unsigned                         NUM_SLICES = 4,
  parameter logic [SLICE_W*NUM_SLICES-1:0]       RELOAD_RST = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [SLICE_W*NUM_SLICES-1:0] cmd_data,
  input  logic                          auto_reload,
  input  logic                          tick,
  output logic [SLICE_W*NUM_SLICES-1:0] count,
  output logic                          busy,
  output logic                          expire,
  output logic [NUM_SLICES-1:0]         slice_carry
`ifdef CNT163_PRESCALE_EN
  ,
  input  logic [7:0]                    prescale
`endif
);

  localparam int unsigned W = SLICE_W * NUM_SLICES;

  state_e         state_q, state_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           ar_q, ar_d;

  cmd_op_e        op;
  logic           acc, do_load, do_start, do_stop;
  logic           tick_q, adv, wrap;
  logic           ld_all;
  logic [W-1:0]   ld_data;
  logic [NUM_SLICES-1:0] cen;

  assign op       = cmd_op_e'(cmd_op);
  assign acc      = cmd_valid & cmd_ready;
  assign do_load  = acc & (op == OP_LOAD);
  assign do_start = acc & (op == OP_START);
  assign do_stop  = acc & (op == OP_STOP);

  // LOAD and STOP accepted in the same cycle take priority over a tick.
  assign tick_q = (state_q == ST_RUN) & tick & ~do_load & ~do_stop;

`ifdef CNT163_PRESCALE_EN
  logic [7:0] psc_q, psc_d;
  logic       psc_hit;

  assign psc_hit = (psc_q == prescale);
  assign adv     = tick_q & psc_hit;

  always_comb begin
    psc_d = psc_q;
    if (do_start | do_load | do_stop) begin
      psc_d = '0;
    end else if (tick_q) begin
      psc_d = psc_hit ? '0 : psc_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psc_q <= '0;
    else        psc_q <= psc_d;
  end
`else
  assign adv = tick_q;
`endif

  assign wrap = adv & (count == '1);

  // On wrap without auto-reload the cascade rolls over to zero by itself;
  // only the auto-reload case needs a parallel load of the reload value.
  assign ld_all  = do_load | (wrap & auto_reload);
  assign ld_data = do_load ? cmd_data : reload_q;

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    if (k == 0) begin : g_first
      assign cen[k] = adv;
    end else begin : g_rest
      assign cen[k] = slice_carry[k-1];
    end

    cnt163_slice u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld_all),
      .d     (ld_data[k*SLICE_W +: SLICE_W]),
      .cen   (cen[k]),
      .q     (count[k*SLICE_W +: SLICE_W]),
      .co    (slice_carry[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      reload_q <= RELOAD_RST;
      ar_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      ar_q     <= ar_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    reload_d = do_load ? cmd_data : reload_q;
    ar_d     = wrap ? auto_reload : ar_q;
    unique case (state_q)
      ST_IDLE: begin
        if (do_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (do_stop)   state_d = ST_IDLE;
        else if (wrap) state_d = ST_EXPIRE;
      end
      ST_EXPIRE: begin
        state_d = ar_q ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q != ST_EXPIRE);
    busy      = (state_q == ST_RUN);
    expire    = (state_q == ST_EXPIRE);
  end

endmodule

// File: tb/tb_cnt163_seq_ctrl.sv
// Self-checking bench for cnt163_seq_ctrl: directed scenarios followed by
// randomized commands/ticks compared against a behavioural timer model.
module tb_cnt163_seq_ctrl;

  localparam int unsigned NS  = 4;
  localparam int unsigned W   = 4 * NS;
  localparam int unsigned MOD = 1 << W;
  localparam int unsigned MAXV = MOD - 1;

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, START = 2'b10, STOP = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic          auto_reload;
  logic          tick;
  logic [W-1:0]  count;
  logic          busy;
  logic          expire;
  logic [NS-1:0] slice_carry;
`ifdef CNT163_PRESCALE_EN
  logic [7:0]    prescale;
`endif

  cnt163_seq_ctrl #(.NUM_SLICES(NS), .RELOAD_RST('0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .auto_reload (auto_reload),
    .tick        (tick),
    .count       (count),
    .busy        (busy),
    .expire      (expire),
    .slice_carry (slice_carry)
`ifdef CNT163_PRESCALE_EN
    ,
    .prescale    (prescale)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: a running flag, an expiry-pending flag and plain integers.
  int unsigned m_count, m_reload;
  bit          m_run, m_exp, m_exp_ar;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_run = 0; m_exp = 0; m_exp_ar = 0;
  endtask

  task automatic check_outputs(input logic v, input logic [1:0] op, input logic tk);
    bit acc, adv;
    logic [NS-1:0] ec;
    int unsigned mask;
    acc = v && !m_exp;
    adv = m_run && !m_exp && tk && !(acc && (op == LOAD || op == STOP));
    for (int k = 0; k < NS; k++) begin
      mask  = (32'd1 << (4 * (k + 1))) - 1;
      ec[k] = adv && ((m_count & mask) == mask);
    end
    chk("count",  {16'd0, count}, m_count);
    chk("ready",  {31'd0, cmd_ready}, {31'd0, !m_exp});
    chk("busy",   {31'd0, busy}, {31'd0, m_run});
    chk("expire", {31'd0, expire}, {31'd0, m_exp});
    chk("carry",  {28'd0, slice_carry}, {28'd0, ec});
  endtask

  task automatic model_update(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                              input logic tk, input logic ar);
    bit acc;
    acc = v && !m_exp;
    if (m_exp) begin
      m_exp = 0;
      m_run = m_exp_ar;
    end else if (acc && op == LOAD) begin
      m_reload = d;
      m_count  = d;
    end else if (acc && op == STOP && m_run) begin
      m_run = 0;
    end else if (acc && op == START && !m_run) begin
      m_run = 1;
    end else if (m_run && tk) begin
      if (m_count == MAXV) begin
        m_count  = ar ? m_reload : 0;
        m_exp    = 1;
        m_exp_ar = ar;
        m_run    = 0;
      end else begin
        m_count = (m_count + 1) % MOD;
      end
    end
  endtask

  // One clock cycle: drive, check pre-edge outputs, clock, advance the model.
  task automatic step(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                      input logic tk, input logic ar);
    cmd_valid = v; cmd_op = op; cmd_data = d; tick = tk; auto_reload = ar;
    #1;
    check_outputs(v, op, tk);
    @(posedge clk);
    model_update(v, op, d, tk, ar);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_op = NOP; cmd_data = '0; tick = 0; auto_reload = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          hv, htk, har;
    logic [1:0]    hop;
    logic [W-1:0]  hd;
    bit            hold;

    rst_n = 1'b0;
`ifdef CNT163_PRESCALE_EN
    prescale = 8'd0;
`endif
    apply_reset();
    chk("rst_count",  {16'd0, count}, 32'h0);
    chk("rst_ready",  {31'd0, cmd_ready}, 32'h1);
    chk("rst_busy",   {31'd0, busy}, 32'h0);
    chk("rst_expire", {31'd0, expire}, 32'h0);
    chk("rst_carry",  {28'd0, slice_carry}, 32'h0);

    // Auto-reload wrap from FFFD.
    step(1, LOAD, 16'hFFFD, 0, 1);
    step(1, START, '0, 0, 1);
    step(0, NOP, '0, 1, 1);
    chk("p1_fffe", {16'd0, count}, 32'hFFFE);
    step(0, NOP, '0, 1, 1);
    chk("p1_ffff", {16'd0, count}, 32'hFFFF);
    step(0, NOP, '0, 1, 1);
    chk("p1_reload", {16'd0, count}, 32'hFFFD);
    chk("p1_expire", {31'd0, expire}, 32'h1);
    step(0, NOP, '0, 1, 1);
    chk("p1_noexp", {31'd0, expire}, 32'h0);
    chk("p1_busy",  {31'd0, busy}, 32'h1);
    chk("p1_tick_ignored", {16'd0, count}, 32'hFFFD);

    // Carry ripple through two slices.
    step(1, STOP, '0, 0, 0);
    step(1, LOAD, 16'h00FF, 0, 0);
    step(1, START, '0, 0, 0);
    cmd_valid = 0; cmd_op = NOP; tick = 1; #1;
    chk("p2_carry", {28'd0, slice_carry}, 32'h3);
    step(0, NOP, '0, 1, 0);
    chk("p2_count", {16'd0, count}, 32'h0100);
    chk("p2_noexp", {31'd0, expire}, 32'h0);

    // Wrap to zero and stop.
    step(1, LOAD, 16'hFFFF, 0, 0);
    step(0, NOP, '0, 1, 0);
    chk("p3_zero", {16'd0, count}, 32'h0);
    chk("p3_expire", {31'd0, expire}, 32'h1);
    step(0, NOP, '0, 1, 0);
    chk("p3_idle", {31'd0, busy}, 32'h0);
    step(0, NOP, '0, 1, 0);
    step(0, NOP, '0, 1, 0);
    chk("p3_frozen", {16'd0, count}, 32'h0);

    // STOP wins over a same-cycle tick.
    step(1, START, '0, 0, 0);
    step(0, NOP, '0, 1, 0);
    step(1, STOP, '0, 1, 0);
    chk("p4_count", {16'd0, count}, 32'h1);
    chk("p4_busy",  {31'd0, busy}, 32'h0);
    chk("p4_ready", {31'd0, cmd_ready}, 32'h1);

    // Command held during EXPIRE is taken the next cycle.
    step(1, LOAD, 16'hFFFF, 0, 1);
    step(1, START, '0, 0, 1);
    step(0, NOP, '0, 1, 1);
    cmd_valid = 1; cmd_op = LOAD; cmd_data = 16'h1234; tick = 0; #1;
    chk("p5_notready", {31'd0, cmd_ready}, 32'h0);
    step(1, LOAD, 16'h1234, 0, 1);
    step(1, LOAD, 16'h1234, 0, 1);
    chk("p5_count", {16'd0, count}, 32'h1234);

    // All-ones reload with auto-reload expires on every tick.
    step(1, LOAD, 16'hFFFF, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, NOP, '0, 1, 1);
      chk("p6_expire", {31'd0, expire}, 32'h1);
      step(0, NOP, '0, 1, 1);
    end

    // Asynchronous reset while EXPIRE is pending.
    step(0, NOP, '0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_count",  {16'd0, count}, 32'h0);
    chk("rst_mid_expire", {31'd0, expire}, 32'h0);
    chk("rst_mid_busy",   {31'd0, busy}, 32'h0);
    apply_reset();
    step(1, START, '0, 0, 0);
    step(0, NOP, '0, 1, 0);
    chk("rst_reload0", {16'd0, count}, 32'h1);

    // Randomized traffic; a command offered during EXPIRE is held until taken.
    hold = 0; hv = 0; hop = NOP; hd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        hv  = ($urandom_range(99) < 20);
        hop = 2'($urandom_range(3));
        hd  = ($urandom_range(1) == 1) ? 16'($urandom) : 16'hFFF0 | 16'($urandom_range(15));
      end
      htk = ($urandom_range(99) < 75);
      har = 1'($urandom_range(1));
      hold = hv && m_exp;
      step(hv, hop, hd, htk, har);
    end

`ifdef CNT163_PRESCALE_EN
    apply_reset();
    prescale = 8'd2;
    cmd_valid = 1; cmd_op = START; tick = 0;
    @(posedge clk); #1;
    cmd_valid = 0; tick = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("psc_count", {16'd0, count}, 32'h2);
    tick = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("psc_rst", {16'd0, count}, 32'h0);
    #3 rst_n = 1'b1;
    prescale = 8'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
